// File: rtl/alu_serial_rx.sv
// ALU-side receiver: deserializes 11-bit frames on sin into {A,B,op,err} packets.
// Define ALU_RX_CRC_CHECK_EN to build the CRC-4 checker; otherwise err_crc is tied 0.
module alu_serial_rx #(
  parameter int DATA_FRAMES = 8,
  parameter bit WAIT_IDLE   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 1);

  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} bit_state_t;

  bit_state_t       state;
  logic [3:0]       bit_cnt;
  logic [8:0]       sr;
  logic             frame_done;
  logic             frame_ctl;
  logic [7:0]       frame_byte;

  logic [63:0]      ab;
  logic [CNT_W-1:0] cnt;
  logic             cnt_full;
  logic [2:0]       cmd_op;
  logic             op_bad;
  logic             crc_bad;

  logic             pkt_done;
  logic [31:0]      pkt_a;
  logic [31:0]      pkt_b;
  logic [2:0]       pkt_op;
  logic [2:0]       pkt_err;

  // Start bit is consumed in IDLE; SHIFT collects ctl, 8 payload bits and the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (WAIT_IDLE) state <= WAIT_HI;
      else           state <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      frame_done <= 1'b0;
      frame_ctl  <= 1'b0;
      frame_byte <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_HI: if (sin) state <= IDLE;
        IDLE: begin
          if (!sin) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (bit_cnt == 4'd9) begin
            if (sin) begin
              frame_done <= 1'b1;
              frame_ctl  <= sr[8];
              frame_byte <= sr[7:0];
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              if (WAIT_IDLE) state <= WAIT_HI;
              else           state <= IDLE;
            end
          end else begin
            sr      <= {sr[7:0], sin};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

  assign cnt_full = (cnt == CNT_W'(DATA_FRAMES));
  assign cmd_op   = frame_byte[6:4];
  assign op_bad   = !(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101});

`ifdef ALU_RX_CRC_CHECK_EN
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign crc_bad = (crc4({ab, 1'b1, cmd_op}) != frame_byte[3:0]);
`else
  assign crc_bad = 1'b0;
`endif

  // Assemble operands; any packet emission (good or not) restarts the byte count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ab       <= '0;
      cnt      <= '0;
      pkt_done <= 1'b0;
      pkt_a    <= '0;
      pkt_b    <= '0;
      pkt_op   <= '0;
      pkt_err  <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (frame_err) begin
        cnt <= '0;
        ab  <= '0;
      end else if (frame_done) begin
        if (!frame_ctl && !cnt_full) begin
          ab  <= {ab[55:0], frame_byte};
          cnt <= cnt + 1'b1;
        end else begin
          pkt_done <= 1'b1;
          pkt_a    <= ab[63:32];
          pkt_b    <= ab[31:0];
          cnt      <= '0;
          ab       <= '0;
          if (!frame_ctl) begin
            pkt_op  <= 3'b000;
            pkt_err <= 3'b001;
          end else begin
            pkt_op  <= cmd_op;
            pkt_err <= {crc_bad && cnt_full, op_bad, !cnt_full};
          end
        end
      end
    end
  end

  // Output holding register: a completion that cannot be accepted is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pkt_done) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_a     <= pkt_a;
          out_b     <= pkt_b;
          out_op    <= pkt_op;
          out_err   <= pkt_err;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: frames are driven on negedge, outputs sampled 1ns after posedge.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;
  logic        frame_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;

  alu_serial_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference CRC as polynomial long division of msg*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {a, b, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic ctl, input logic [7:0] payload, input logic stop);
    send_bit(1'b0);
    send_bit(ctl);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
    send_bit(stop);
  endtask

  task automatic send_operands(input logic [31:0] a, input logic [31:0] b);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, b[i*8 +: 8], 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called right after the cmd stop bit is driven: checks the 2-clock latency and the packet.
  task automatic check_output(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [2:0] err);
    step();
    check({tag, ".valid_t0"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".valid_t1"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".valid_t2"}, 32'(out_valid), 32'd1);
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".op"}, 32'(out_op), 32'(op));
    check({tag, ".err"}, 32'(out_err), 32'(err));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    sin       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.a", out_a, 32'd0);
    check("reset.b", out_b, 32'd0);
    check("reset.op", 32'(out_op), 32'd0);
    check("reset.err", 32'(out_err), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    check("reset.overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    $display("[TB] test 1: good ADD packet");
    send_operands(32'h0000_0005, 32'h0000_0003);
    send_cmd(3'b100, ref_crc(32'h5, 32'h3, 3'b100));
    check_output("t1", 32'h5, 32'h3, 3'b100, 3'b000);
    step();
    check("t1.valid_drop", 32'(out_valid), 32'd0);
    idle(2);

    $display("[TB] test 2: corrupted crc field");
    send_operands(32'h0000_0005, 32'h0000_0003);
    send_cmd(3'b100, ref_crc(32'h5, 32'h3, 3'b100) ^ 4'h1);
`ifdef ALU_RX_CRC_CHECK_EN
    check_output("t2", 32'h5, 32'h3, 3'b100, 3'b100);
`else
    check_output("t2", 32'h5, 32'h3, 3'b100, 3'b000);
`endif
    idle(3);

    $display("[TB] test 3: short packet then good packet");
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b1);
    send_cmd(3'b000, 4'h0);
    step();
    step();
    step();
    check("t3.short_valid", 32'(out_valid), 32'd1);
    check("t3.short_err", 32'(out_err), 32'd1);
    idle(2);
    send_operands(32'hA5A5_0F0F, 32'h1234_0001);
    send_cmd(3'b001, ref_crc(32'hA5A5_0F0F, 32'h1234_0001, 3'b001));
    check_output("t3.good", 32'hA5A5_0F0F, 32'h1234_0001, 3'b001, 3'b000);
    idle(3);

    $display("[TB] test 4: framing error mid-packet");
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h88, 1'b1);
    send_frame(1'b0, 8'hA5, 1'b0);
    step();
    check("t4.frame_err_pulse", 32'(frame_err), 32'd1);
    step();
    check("t4.frame_err_clear", 32'(frame_err), 32'd0);
    check("t4.no_valid", 32'(out_valid), 32'd0);
    idle(3);
    send_operands(32'hDEAD_BEEF, 32'h0102_0304);
    send_cmd(3'b101, ref_crc(32'hDEAD_BEEF, 32'h0102_0304, 3'b101));
    check_output("t4.good", 32'hDEAD_BEEF, 32'h0102_0304, 3'b101, 3'b000);
    idle(3);

    $display("[TB] test 5: consumer stalled, overrun");
    out_ready = 1'b0;
    send_operands(32'h0000_0001, 32'h0000_0007);
    send_cmd(3'b000, ref_crc(32'h1, 32'h7, 3'b000));
    check_output("t5.first", 32'h1, 32'h7, 3'b000, 3'b000);
    idle(3);
    send_operands(32'h0000_0002, 32'h0000_0007);
    send_cmd(3'b000, ref_crc(32'h2, 32'h7, 3'b000));
    step();
    check("t5.ovr_t0", 32'(overrun), 32'd0);
    step();
    check("t5.ovr_t1", 32'(overrun), 32'd0);
    step();
    check("t5.ovr_t2", 32'(overrun), 32'd1);
    check("t5.held_valid", 32'(out_valid), 32'd1);
    check("t5.held_a", out_a, 32'h1);
    step();
    check("t5.ovr_t3", 32'(overrun), 32'd0);
    check("t5.still_a", out_a, 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    check("t5.valid_drop", 32'(out_valid), 32'd0);
    idle(2);

    $display("[TB] test 6: reset mid-packet, invalid op");
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'hF0 + 8'(i), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    step();
    check("t6.reset_a", out_a, 32'd0);
    check("t6.reset_b", out_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    send_operands(32'h1234_5678, 32'h9ABC_DEF0);
    send_cmd(3'b011, ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b011));
    check_output("t6", 32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 3'b010);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
